// File: rtl/mlaccel_pkg.sv
// Shared types and defaults for the mlaccel shared-memory arbiter slice.
package mlaccel_pkg;

    localparam int NREQ_DEF   = 3;
    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;

    localparam int REQ_HOST = 0;
    localparam int REQ_SEQ  = 1;
    localparam int REQ_DMA  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } arb_state_e;

    function automatic int mod_add(input int a, input int b, input int n);
        return (a + b) % n;
    endfunction

endpackage

// File: rtl/mlaccel_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward from last+1, wrapping at NREQ.
module mlaccel_rr_pick
    import mlaccel_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand_s;
    logic             hit_s;

    // Scan from farthest to nearest so the nearest hit after last_i is the final assignment.
    always_comb begin
        any_o  = 1'b0;
        idx_o  = '0;
        cand_s = '0;
        hit_s  = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            cand_s = IDX_W'(mod_add(int'(last_i), i, NREQ));
            hit_s  = req_i[cand_s];
            any_o  = any_o | hit_s;
            idx_o  = hit_s ? cand_s : idx_o;
        end
    end

endmodule

// File: rtl/mlaccel_smem_arbiter.sv
// Round-robin arbiter sharing the single-port smem between host, sequencer and DMA, one transaction at a time.
// Define MLACCEL_SMEM_ARB_HOSTPRIO_EN to give the host (requester 0) strict priority over round-robin.
module mlaccel_smem_arbiter
    import mlaccel_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = $clog2(NREQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_wen,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [DATA_W-1:0]        req_rdata,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic                     mem_wen,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [IDX_W-1:0]         grant_id,
    output logic                     arb_busy
);

    arb_state_e         state_q;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   grant_id_q;
    logic               mem_valid_q;
    logic               mem_wen_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [DATA_W-1:0]  mem_wdata_q;
    logic [DATA_W-1:0]  req_rdata_q;
    logic [NREQ-1:0]    req_ready_q;

    logic               rr_any_s;
    logic [IDX_W-1:0]   rr_idx_s;
    logic [IDX_W-1:0]   grant_d;
    logic [IDX_W-1:0]   last_d;
    logic               wen_sel_s;
    logic [ADDR_W-1:0]  addr_sel_s;
    logic [DATA_W-1:0]  wdata_sel_s;
    logic [NREQ-1:0]    ready_onehot_s;

    mlaccel_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i  (req_valid),
        .last_i (last_q),
        .any_o  (rr_any_s),
        .idx_o  (rr_idx_s)
    );

    // Winner selection and pointer update; host grants leave the pointer alone in priority builds.
    always_comb begin
        grant_d = rr_idx_s;
        last_d  = grant_id_q;
`ifdef MLACCEL_SMEM_ARB_HOSTPRIO_EN
        if (req_valid[REQ_HOST]) begin
            grant_d = IDX_W'(REQ_HOST);
        end else begin
            grant_d = rr_idx_s;
        end
        if (grant_id_q == IDX_W'(REQ_HOST)) begin
            last_d = last_q;
        end else begin
            last_d = grant_id_q;
        end
`endif
    end

    // Mux the winning slice and build the completion one-hot.
    always_comb begin
        wen_sel_s      = 1'b0;
        addr_sel_s     = '0;
        wdata_sel_s    = '0;
        ready_onehot_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            wen_sel_s         = (grant_d == IDX_W'(i)) ? req_wen[i] : wen_sel_s;
            addr_sel_s        = (grant_d == IDX_W'(i)) ? req_addr[i*ADDR_W +: ADDR_W] : addr_sel_s;
            wdata_sel_s       = (grant_d == IDX_W'(i)) ? req_wdata[i*DATA_W +: DATA_W] : wdata_sel_s;
            ready_onehot_s[i] = (grant_id_q == IDX_W'(i));
        end
    end

    // Arbiter FSM; a reset mid-access abandons the transaction without a completion pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            last_q      <= IDX_W'(NREQ - 1);
            grant_id_q  <= '0;
            mem_valid_q <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            req_rdata_q <= '0;
            req_ready_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rr_any_s) begin
                        grant_id_q  <= grant_d;
                        mem_wen_q   <= wen_sel_s;
                        mem_addr_q  <= addr_sel_s;
                        mem_wdata_q <= wdata_sel_s;
                        mem_valid_q <= 1'b1;
                        state_q     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ready) begin
                        mem_valid_q <= 1'b0;
                        req_rdata_q <= mem_rdata;
                        req_ready_q <= ready_onehot_s;
                        last_q      <= last_d;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    req_ready_q <= '0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    mem_valid_q <= 1'b0;
                    req_ready_q <= '0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign req_rdata = req_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_wen   = mem_wen_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant_id  = grant_id_q;
    assign arb_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mlaccel_smem_arbiter.sv
// Directed self-checking bench for mlaccel_smem_arbiter (NREQ=3, ADDR_W=16, DATA_W=32).
module tb_mlaccel_smem_arbiter;

    logic          clock;
    logic          reset;
    logic [2:0]    req_valid;
    logic [2:0]    req_wen;
    logic [47:0]   req_addr;
    logic [95:0]   req_wdata;
    logic [2:0]    req_ready;
    logic [31:0]   req_rdata;
    logic          mem_valid;
    logic          mem_ready;
    logic          mem_wen;
    logic [15:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [1:0]    grant_id;
    logic          arb_busy;

    int total = 0;
    int bad   = 0;
    int txn_cnt = 0;
    int rdy_cnt [3] = '{0, 0, 0};
    int t0;
    int r1_snap;
    logic [15:0] exp_addr [3] = '{16'h0100, 16'h0200, 16'h0300};
    int order2 [6] = '{0, 1, 2, 0, 1, 2};

    mlaccel_smem_arbiter #(.NREQ(3), .ADDR_W(16), .DATA_W(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .req_rdata (req_rdata),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wen   (mem_wen),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy)
    );

    always #5 clock = ~clock;

    // Count completed memory transactions and completion pulses per requester.
    always @(posedge clock) begin
        if (mem_valid && mem_ready) txn_cnt <= txn_cnt + 1;
        for (int i = 0; i < 3; i++) begin
            if (req_ready[i]) rdy_cnt[i] <= rdy_cnt[i] + 1;
        end
    end

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic wen, input logic [15:0] a, input logic [31:0] d);
        req_wen[i]           = wen;
        req_addr[i*16 +: 16] = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    // Entered in the grant cycle; mem_ready is returned with the first mem_valid.
    task automatic serve(input int g);
        logic [2:0] oh;
        oh = 3'b001 << g;
        chk($sformatf("srv%0d_grant", g), grant_id, g);
        chk($sformatf("srv%0d_mem_valid", g), mem_valid, 1'b1);
        chk($sformatf("srv%0d_mem_addr", g), mem_addr, exp_addr[g]);
        mem_ready = 1'b1;
        mem_rdata = 32'hA000_0000 + g;
        step;
        chk($sformatf("srv%0d_ready", g), req_ready, oh);
        chk($sformatf("srv%0d_rdata", g), req_rdata, 32'hA000_0000 + g);
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        step;
        chk($sformatf("srv%0d_ready_clr", g), req_ready, 3'b000);
    endtask

    initial begin
        clock = 1'b0; reset = 1'b1; req_valid = 3'b000; req_wen = 3'b000;
        req_addr = 48'h0; req_wdata = 96'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
        step; step;
        chk("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_mem_wen",   mem_wen,   1'b0);
        chk("rst_req_ready", req_ready, 3'b000);
        chk("rst_busy",      arb_busy,  1'b0);
        chk("rst_grant",     grant_id,  2'd0);
        chk("rst_mem_addr",  mem_addr,  16'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_req_rdata", req_rdata, 32'h0);

        // Single read from the sequencer, memory answers two cycles after mem_valid
        reset = 1'b0;
        set_req(1, 1'b0, 16'h0040, 32'h0);
        req_valid = 3'b010;
        t0 = txn_cnt;
        step;
        chk("t1_mem_valid", mem_valid, 1'b1);
        chk("t1_mem_addr",  mem_addr,  16'h0040);
        chk("t1_mem_wen",   mem_wen,   1'b0);
        chk("t1_grant",     grant_id,  2'd1);
        chk("t1_busy",      arb_busy,  1'b1);
        step;
        chk("t1_hold_valid", mem_valid, 1'b1);
        chk("t1_no_ready",   req_ready, 3'b000);
        step;
        mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        step;
        chk("t1_ready",      req_ready, 3'b010);
        chk("t1_rdata",      req_rdata, 32'hDEADBEEF);
        chk("t1_valid_drop", mem_valid, 1'b0);
        mem_ready = 1'b0; mem_rdata = 32'h0;
        step;
        chk("t1_ready_clr", req_ready, 3'b000);
        chk("t1_idle",      arb_busy,  1'b0);
        req_valid = 3'b000;
        step;
        chk("t1_no_regrant", mem_valid, 1'b0);
        chk("t1_one_txn",    txn_cnt - t0, 1);

        // All three request continuously after reset
        reset = 1'b1;
        set_req(0, 1'b0, 16'h0100, 32'h0);
        set_req(1, 1'b0, 16'h0200, 32'h0);
        set_req(2, 1'b0, 16'h0300, 32'h0);
        req_valid = 3'b111;
        step;
        reset = 1'b0;
        step;
        for (int k = 0; k < 6; k++) begin
            serve(order2[k]);
            step;
        end

        // Write from DMA, memory completes with the first mem_valid
        reset = 1'b1; req_valid = 3'b000;
        step;
        reset = 1'b0;
        set_req(2, 1'b1, 16'h1000, 32'h12345678);
        req_valid = 3'b100;
        step;
        chk("t3_valid", mem_valid, 1'b1);
        chk("t3_wen",   mem_wen,   1'b1);
        chk("t3_addr",  mem_addr,  16'h1000);
        chk("t3_wdata", mem_wdata, 32'h12345678);
        chk("t3_grant", grant_id,  2'd2);
        mem_ready = 1'b1;
        step;
        chk("t3_ready", req_ready, 3'b100);
        mem_ready = 1'b0;
        step;
        chk("t3_gap_valid", mem_valid, 1'b0);
        chk("t3_ready_clr", req_ready, 3'b000);
        step;
        chk("t3_regrant", mem_valid, 1'b1);
        mem_ready = 1'b1;
        step;
        chk("t3_ready2", req_ready, 3'b100);
        mem_ready = 1'b0; req_valid = 3'b000;
        set_req(2, 1'b0, 16'h0300, 32'h0);
        step;

        // Reset during ACCESS aborts the transaction, then host wins; requester 1 withdraws before grant
        reset = 1'b1;
        step;
        reset = 1'b0;
        req_valid = 3'b010;
        step;
        chk("t4_grant", grant_id, 2'd1);
        chk("t4_valid", mem_valid, 1'b1);
        r1_snap = rdy_cnt[1];
        reset = 1'b1; mem_ready = 1'b1;
        step;
        chk("t4_valid_drop", mem_valid, 1'b0);
        chk("t4_busy",       arb_busy,  1'b0);
        chk("t4_no_ready",   req_ready, 3'b000);
        reset = 1'b0; mem_ready = 1'b0;
        req_valid = 3'b111;
        step;
        chk("t4_host_first", grant_id, 2'd0);
        req_valid = 3'b101;
        serve(0);
        req_valid = 3'b100;
        step;
        chk("t5_skip_to_2", grant_id, 2'd2);
        serve(2);
        req_valid = 3'b000;
        step;
        chk("t5_quiet", mem_valid, 1'b0);
        chk("t5_req1_never", rdy_cnt[1] - r1_snap, 0);

`ifdef MLACCEL_SMEM_ARB_HOSTPRIO_EN
        // Host priority: host starves the others until it stops, then 1 and 2 alternate
        reset = 1'b1; req_valid = 3'b111;
        step;
        reset = 1'b0;
        step;
        serve(0); step;
        serve(0); step;
        serve(0);
        req_valid = 3'b110;
        step;
        serve(1); step;
        serve(2); step;
        serve(1);
        req_valid = 3'b000;
        step;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
